// File: rtl/cvmcu_dbg_req_ctrl_pkg.sv
package cvmcu_dbg_req_ctrl_pkg;

  localparam int unsigned DEF_NUM_SRC    = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;
  localparam int unsigned DEF_RESUME_DLY = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2,
    RESUME = 2'd3
  } dbg_ctrl_state_t;

  // Width of the counter shared between the REQ timeout and the RESUME hold.
  function automatic int unsigned dbg_cnt_width(input int unsigned timeout,
                                                input int unsigned resume_dly);
    int unsigned m;
    m = 2;
    if (timeout > m)    m = timeout;
    if (resume_dly > m) m = resume_dly;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cvmcu_dbg_req_ctrl_if.sv
interface cvmcu_dbg_req_ctrl_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0] src_req_i;
  logic [NUM_SRC-1:0] src_ack_o;
  logic               debug_req_o;
  logic               debug_mode_i;

  modport master (
    output src_req_i,
    output debug_mode_i,
    input  src_ack_o,
    input  debug_req_o
  );

  modport slave (
    input  src_req_i,
    input  debug_mode_i,
    output src_ack_o,
    output debug_req_o
  );
endinterface

// File: rtl/cvmcu_dbg_req_ctrl_arb.sv
module cvmcu_dbg_rr_arb #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_gnt_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned cand;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(last_gnt_i) + 1 + k) % N;
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        valid_o                = 1'b1;
        gnt_o[cand[IW-1:0]]    = 1'b1;
        idx_o                  = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cvmcu_dbg_req_ctrl.sv
module cvmcu_dbg_req_ctrl
  import cvmcu_dbg_req_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned RESUME_DLY = DEF_RESUME_DLY
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cvmcu_dbg_req_ctrl_if.slave   dbg,
  input  logic                  stop_en_i,
  output logic                  stoptimer_o,
  output logic                  timeout_o,
  output logic                  busy_o
);

  localparam int unsigned IW = $clog2(NUM_SRC);
  localparam int unsigned CW = dbg_cnt_width(TIMEOUT, RESUME_DLY);

  dbg_ctrl_state_t    state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d, pending_clr;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      last_gnt_q, last_gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               to_q, to_d;
  logic               dreq_q, stop_q, busy_q;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

  cvmcu_dbg_rr_arb #(
    .N (NUM_SRC)
  ) u_arb (
    .req_i      (pending_q),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (arb_gnt),
    .idx_o      (arb_idx),
    .valid_o    (arb_valid)
  );

  // The winner is held one-hot so ack and pending-clear need no decode.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    to_d        = 1'b0;
    pending_clr = '0;
    case (state_q)
      IDLE: begin
        if (dbg.debug_mode_i) begin
          state_d = HALTED;
        end else if (arb_valid) begin
          state_d    = REQ;
          cnt_d      = '0;
          gnt_d      = arb_gnt;
          last_gnt_d = arb_idx;
        end
      end
      REQ: begin
        if (dbg.debug_mode_i) begin
          state_d     = HALTED;
          ack_d       = gnt_q;
          pending_clr = gnt_q;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d     = IDLE;
          to_d        = 1'b1;
          pending_clr = gnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HALTED: begin
        if (!dbg.debug_mode_i) begin
          if (RESUME_DLY == 0) begin
            state_d = IDLE;
          end else begin
            state_d = RESUME;
            cnt_d   = '0;
          end
        end
      end
      RESUME: begin
        if (dbg.debug_mode_i) begin
          state_d = HALTED;
        end else if (cnt_q == CW'(RESUME_DLY - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | dbg.src_req_i) & ~pending_clr;
  end

  // Outputs are registered from the next-state decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      gnt_q      <= '0;
      last_gnt_q <= IW'(NUM_SRC - 1);
      cnt_q      <= '0;
      ack_q      <= '0;
      to_q       <= 1'b0;
      dreq_q     <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      to_q       <= to_d;
      dreq_q     <= (state_d == REQ);
      stop_q     <= stop_en_i && ((state_d == HALTED) || (state_d == RESUME));
      busy_q     <= (state_d != IDLE);
    end
  end

  assign dbg.src_ack_o   = ack_q;
  assign dbg.debug_req_o = dreq_q;
  assign stoptimer_o     = stop_q;
  assign timeout_o       = to_q;
  assign busy_o          = busy_q;

endmodule
